// File: rtl/fence_flush_sequencer_if.sv
// Commit-side and cache/TLB-side signals of the fence/flush sequencer.
// Request handshake: a request transfers on a clock edge where req_valid_i && req_ready_o; the requester holds req_valid_i and req_kind_i until then.
interface fence_flush_sequencer_if;
  logic       req_valid_i;
  logic [1:0] req_kind_i;
  logic       req_ready_o;
  logic       sb_empty_i;
  logic       flush_dcache_o;
  logic       flush_dcache_ack_i;
  logic       flush_icache_o;
  logic       flush_tlb_o;
  logic       halt_o;
  logic       halt_frontend_o;
  logic       set_pc_commit_o;
  logic       done_o;
  logic       timeout_o;
  logic [2:0] dbg_state_o;

  modport slave (
    input  req_valid_i,
    input  req_kind_i,
    input  sb_empty_i,
    input  flush_dcache_ack_i,
    output req_ready_o,
    output flush_dcache_o,
    output flush_icache_o,
    output flush_tlb_o,
    output halt_o,
    output halt_frontend_o,
    output set_pc_commit_o,
    output done_o,
    output timeout_o,
    output dbg_state_o
  );

  modport master (
    output req_valid_i,
    output req_kind_i,
    output sb_empty_i,
    output flush_dcache_ack_i,
    input  req_ready_o,
    input  flush_dcache_o,
    input  flush_icache_o,
    input  flush_tlb_o,
    input  halt_o,
    input  halt_frontend_o,
    input  set_pc_commit_o,
    input  done_o,
    input  timeout_o,
    input  dbg_state_o
  );
endinterface

// File: rtl/fence_flush_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA: store-buffer drain, DCache flush, ICache invalidate, TLB flush, PC resync.
// Every output is decoded from registered state only.
module fence_flush_sequencer #(
  parameter bit          DCACHE_FLUSH_EN  = 1'b1,
  parameter int unsigned TLB_FLUSH_CYCLES = 2,
  parameter int unsigned TIMEOUT_W        = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  fence_flush_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_DFLUSH = 3'd2,
    S_IFLUSH = 3'd3,
    S_TLB    = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [1:0] KIND_FENCE   = 2'b00;
  localparam logic [1:0] KIND_FENCE_I = 2'b01;
  localparam logic [1:0] KIND_SFENCE  = 2'b10;

  localparam logic [3:0]           TLB_LOAD  = 4'(TLB_FLUSH_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WDOG_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e               r_state;
  state_e               w_state_nxt;
  logic [1:0]           r_kind;
  logic [1:0]           w_kind_in;
  logic [TIMEOUT_W-1:0] r_wdog;
  logic [3:0]           r_tlb_cnt;
  logic                 r_timeout;
  logic                 w_accept;
  logic                 w_ack;
  logic                 w_tlb_enter;

  // Reserved encoding 11 behaves as a plain FENCE.
  assign w_kind_in   = (bus.req_kind_i == 2'b11) ? KIND_FENCE : bus.req_kind_i;
  assign w_accept    = (r_state == S_IDLE) && bus.req_valid_i;
  assign w_ack       = (r_state == S_DFLUSH) && bus.flush_dcache_ack_i;
  assign w_tlb_enter = (r_state != S_TLB) && (w_state_nxt == S_TLB);

  // State register and counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_kind    <= KIND_FENCE;
      r_wdog    <= '0;
      r_tlb_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_kind <= w_kind_in;
      end
      // Watchdog rests at zero outside DFLUSH, so every DFLUSH visit starts from zero.
      if (r_state != S_DFLUSH) begin
        r_wdog <= '0;
      end else if (!w_ack && (r_wdog != WDOG_MAX)) begin
        r_wdog <= r_wdog + TIMEOUT_W'(1);
      end
      if ((r_state == S_DFLUSH) && !w_ack && (r_wdog == WDOG_LAST)) begin
        r_timeout <= 1'b1;
      end
      if (w_tlb_enter) begin
        r_tlb_cnt <= TLB_LOAD;
      end else if ((r_state == S_TLB) && (r_tlb_cnt != 4'd0)) begin
        r_tlb_cnt <= r_tlb_cnt - 4'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.sb_empty_i) begin
          case (r_kind)
            KIND_FENCE_I: w_state_nxt = DCACHE_FLUSH_EN ? S_DFLUSH : S_IFLUSH;
            KIND_SFENCE:  w_state_nxt = S_TLB;
            default:      w_state_nxt = DCACHE_FLUSH_EN ? S_DFLUSH : S_DONE;
          endcase
        end
      end
      S_DFLUSH: begin
        // No timeout exit: the flush is never abandoned.
        if (bus.flush_dcache_ack_i) begin
          w_state_nxt = (r_kind == KIND_FENCE_I) ? S_IFLUSH : S_DONE;
        end
      end
      S_IFLUSH: w_state_nxt = S_DONE;
      S_TLB: begin
        if (r_tlb_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    bus.req_ready_o     = 1'b0;
    bus.flush_dcache_o  = 1'b0;
    bus.flush_icache_o  = 1'b0;
    bus.flush_tlb_o     = 1'b0;
    bus.halt_o          = 1'b1;
    bus.halt_frontend_o = 1'b0;
    bus.set_pc_commit_o = 1'b0;
    bus.done_o          = 1'b0;
    bus.timeout_o       = r_timeout;
    bus.dbg_state_o     = r_state;
    case (r_state)
      S_IDLE: begin
        bus.req_ready_o = 1'b1;
        bus.halt_o      = 1'b0;
      end
      S_DFLUSH: bus.flush_dcache_o = 1'b1;
      S_IFLUSH: bus.flush_icache_o = 1'b1;
      S_TLB:    bus.flush_tlb_o    = 1'b1;
      S_DONE: begin
        bus.done_o          = 1'b1;
        bus.set_pc_commit_o = 1'b1;
      end
      default: ;
    endcase
    if ((r_kind == KIND_FENCE_I) &&
        ((r_state == S_DRAIN) || (r_state == S_DFLUSH) ||
         (r_state == S_IFLUSH) || (r_state == S_DONE))) begin
      bus.halt_frontend_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_fence_flush_sequencer.sv
// Testbench for fence_flush_sequencer: table of fence scenarios with a scoreboard of expected
// per-sequence timing, plus hand sequences for reset, stray ack, held request and watchdog.
module tb_fence_flush_sequencer;
  localparam int TLBC = 2;
  localparam int TW   = 4;

  typedef struct packed {
    logic [7:0] done_cyc;
    logic [7:0] dfl_first;
    logic [7:0] n_dfl;
    logic [7:0] ic_cyc;
    logic [7:0] tlb_first;
    logic [7:0] n_tlb;
    logic [7:0] n_hfe;
    logic [7:0] to_rise;
  } exp_t;

  typedef struct {
    logic [1:0] kind;
    int         sb_low;
    int         ack_a;
    int         ack_b;
    bit         hold;
    exp_t       ex;
  } vec_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  fence_flush_sequencer_if bus();

  fence_flush_sequencer #(
    .DCACHE_FLUSH_EN (1'b1),
    .TLB_FLUSH_CYCLES(TLBC),
    .TIMEOUT_W       (TW)
  ) u_dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] k, input int sb, input int a, input int b,
                              input bit h, input int dn, input int dff, input int ndf,
                              input int ic, input int tf, input int nt, input int hfe,
                              input int tor);
    vec_t v;
    v.kind = k; v.sb_low = sb; v.ack_a = a; v.ack_b = b; v.hold = h;
    v.ex.done_cyc = 8'(dn);  v.ex.dfl_first = 8'(dff); v.ex.n_dfl = 8'(ndf);
    v.ex.ic_cyc   = 8'(ic);  v.ex.tlb_first = 8'(tf);  v.ex.n_tlb = 8'(nt);
    v.ex.n_hfe    = 8'(hfe); v.ex.to_rise   = 8'(tor);
    return v;
  endfunction

  task automatic start_req(input logic [1:0] kind);
    int w;
    w = 0;
    while (!bus.req_ready_o && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    chk("ready_before_req", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.req_kind_i  = kind;
    @(posedge clk_i);
  endtask

  // Drives one scenario, observes it cycle by cycle and scores it against the queued expectation.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    int   done_c, n_halt, n_rdy, n_ic;
    logic setpc;
    got = '0; done_c = 0; n_halt = 0; n_rdy = 0; n_ic = 0; setpc = 1'b0;
    exp_q.push_back(64'(v.ex));
    start_req(v.kind);
    for (int c = 1; c <= 60 && done_c == 0; c++) begin
      @(negedge clk_i);
      if (bus.flush_dcache_o) begin
        got.n_dfl++;
        if (got.dfl_first == 8'd0) got.dfl_first = 8'(c);
      end
      if (bus.flush_icache_o) begin
        n_ic++;
        if (got.ic_cyc == 8'd0) got.ic_cyc = 8'(c);
      end
      if (bus.flush_tlb_o) begin
        got.n_tlb++;
        if (got.tlb_first == 8'd0) got.tlb_first = 8'(c);
      end
      if (bus.halt_frontend_o) got.n_hfe++;
      if (bus.halt_o) n_halt++;
      if (bus.req_ready_o) n_rdy++;
      if (bus.timeout_o && got.to_rise == 8'd0) got.to_rise = 8'(c);
      if (bus.done_o) begin
        done_c = c;
        setpc  = bus.set_pc_commit_o;
      end
      bus.sb_empty_i         = (c > v.sb_low);
      bus.flush_dcache_ack_i = (c == v.ack_a) || (c == v.ack_b);
      bus.req_valid_i        = v.hold && (c >= 3);
      if (v.hold) bus.req_kind_i = 2'b10;
    end
    bus.flush_dcache_ack_i = 1'b0;
    bus.sb_empty_i         = 1'b1;
    if (done_c == 0) begin
      chk($sformatf("v%0d_done_seen", idx), 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      got.done_cyc = 8'(done_c);
      e = exp_t'(exp_q.pop_front());
      chk($sformatf("v%0d_done_cyc", idx),  32'(got.done_cyc),  32'(e.done_cyc));
      chk($sformatf("v%0d_dfl_first", idx), 32'(got.dfl_first), 32'(e.dfl_first));
      chk($sformatf("v%0d_n_dfl", idx),     32'(got.n_dfl),     32'(e.n_dfl));
      chk($sformatf("v%0d_ic_cyc", idx),    32'(got.ic_cyc),    32'(e.ic_cyc));
      chk($sformatf("v%0d_n_ic", idx),      32'(n_ic),          (e.ic_cyc != 8'd0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_tlb_first", idx), 32'(got.tlb_first), 32'(e.tlb_first));
      chk($sformatf("v%0d_n_tlb", idx),     32'(got.n_tlb),     32'(e.n_tlb));
      chk($sformatf("v%0d_n_hfe", idx),     32'(got.n_hfe),     32'(e.n_hfe));
      chk($sformatf("v%0d_to_rise", idx),   32'(got.to_rise),   32'(e.to_rise));
      chk($sformatf("v%0d_n_halt", idx),    32'(n_halt),        32'(e.done_cyc));
      chk($sformatf("v%0d_busy_ready", idx), 32'(n_rdy),       32'd0);
      chk($sformatf("v%0d_set_pc", idx),    32'(setpc),         32'd1);
    end
    @(negedge clk_i);
    chk($sformatf("v%0d_ready_after", idx), 32'(bus.req_ready_o), 32'd1);
    chk($sformatf("v%0d_halt_after", idx),  32'(bus.halt_o),      32'd0);
    chk($sformatf("v%0d_done_after", idx),  32'(bus.done_o),      32'd0);
  endtask

  // The held SFENCE.VMA is accepted on the edge after the idle cycle that follows DONE.
  task automatic drain_held();
    int done_c, n_tlb;
    done_c = 0; n_tlb = 0;
    @(negedge clk_i);
    chk("held_accept_state", 32'(bus.dbg_state_o), 32'd1);
    chk("held_accept_ready", 32'(bus.req_ready_o), 32'd0);
    bus.req_valid_i = 1'b0;
    for (int c = 2; c <= 30 && done_c == 0; c++) begin
      @(negedge clk_i);
      if (bus.flush_tlb_o) n_tlb++;
      if (bus.done_o) done_c = c;
    end
    chk("held_done_cyc", 32'(done_c), 32'd4);
    chk("held_n_tlb", 32'(n_tlb), 32'd2);
    @(negedge clk_i);
    chk("held_ready_after", 32'(bus.req_ready_o), 32'd1);
  endtask

  initial begin
    bus.req_valid_i        = 1'b0;
    bus.req_kind_i         = 2'b00;
    bus.sb_empty_i         = 1'b1;
    bus.flush_dcache_ack_i = 1'b0;

    //        kind   sb ackA ackB hold done dfl ndf  ic tlbf ntlb hfe to
    vecs[0] = mk(2'd0, 0,  6,  0, 1'b0,  7,  2,  5,  0,  0,  0,  0,  0);
    vecs[1] = mk(2'd1, 3,  5,  0, 1'b0,  7,  5,  1,  6,  0,  0,  7,  0);
    vecs[2] = mk(2'd2, 0,  0,  0, 1'b0,  4,  0,  0,  0,  2,  2,  0,  0);
    vecs[3] = mk(2'd3, 2,  4,  0, 1'b0,  5,  4,  1,  0,  0,  0,  0,  0);
    vecs[4] = mk(2'd2, 4,  3,  0, 1'b0,  8,  0,  0,  0,  6,  2,  0,  0);
    vecs[5] = mk(2'd1, 0,  2,  0, 1'b0,  4,  2,  1,  3,  0,  0,  4,  0);
    vecs[6] = mk(2'd0, 1,  2,  5, 1'b0,  6,  3,  3,  0,  0,  0,  0,  0);
    vecs[7] = mk(2'd1, 1, 10,  0, 1'b0, 12,  3,  8, 11,  0,  0, 12,  0);
    vecs[8] = mk(2'd0, 0,  5,  0, 1'b1,  6,  2,  4,  0,  0,  0,  0,  0);
    vecs[9] = mk(2'd0, 0, 20,  0, 1'b0, 21,  2, 19,  0,  0,  0,  0, 17);

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready",   32'(bus.req_ready_o),    32'd1);
    chk("rst_halt",    32'(bus.halt_o),         32'd0);
    chk("rst_dflush",  32'(bus.flush_dcache_o), 32'd0);
    chk("rst_done",    32'(bus.done_o),         32'd0);
    chk("rst_timeout", 32'(bus.timeout_o),      32'd0);
    chk("rst_state",   32'(bus.dbg_state_o),    32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_state", 32'(bus.dbg_state_o), 32'd0);

    // Stray ack in IDLE
    bus.flush_dcache_ack_i = 1'b1;
    @(negedge clk_i);
    bus.flush_dcache_ack_i = 1'b0;
    chk("stray_ack_state",  32'(bus.dbg_state_o),    32'd0);
    chk("stray_ack_ready",  32'(bus.req_ready_o),    32'd1);
    chk("stray_ack_dflush", 32'(bus.flush_dcache_o), 32'd0);
    @(negedge clk_i);
    chk("stray_ack_state2", 32'(bus.dbg_state_o), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
      if (vecs[i].hold) drain_held();
    end
    chk("timeout_sticky", 32'(bus.timeout_o), 32'd1);

    // Reset during DFLUSH
    bus.sb_empty_i = 1'b1;
    start_req(2'b00);
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_pre_state", 32'(bus.dbg_state_o), 32'd2);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("mid_rst_state",   32'(bus.dbg_state_o),    32'd0);
    chk("mid_rst_dflush",  32'(bus.flush_dcache_o), 32'd0);
    chk("mid_rst_ready",   32'(bus.req_ready_o),    32'd1);
    chk("mid_rst_timeout", 32'(bus.timeout_o),      32'd0);
    chk("mid_rst_halt",    32'(bus.halt_o),         32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk($sformatf("post_rst_idle%0d", k), 32'(bus.flush_dcache_o | bus.halt_o), 32'd0);
    end

    run_vec(10, vecs[2]);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
